// File: rtl/lut_tt_capture.sv
// Exhaustive truth-table capture engine: sweeps x_o over every LUT input vector, waits for the
// response to settle, and streams each captured f_i out with its index and a running signature.
module lut_tt_capture #(
  parameter int unsigned N_INPUTS      = 10,
  parameter int unsigned OUT_WIDTH     = 11,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_INPUTS-1:0]  x_o,
  input  logic [OUT_WIDTH-1:0] f_i,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic [N_INPUTS-1:0]  m_index,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] signature
);

  localparam int unsigned           CntW    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0]       CntLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0]   IdxLast = '1;

  typedef enum logic [1:0] {StIdle, StSettle, StOutput, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [N_INPUTS-1:0]  x_q, x_d;
  logic [N_INPUTS-1:0]  idx_q, idx_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [OUT_WIDTH-1:0] sig_q, sig_d;
  logic                 settled;
  logic                 kill;

  assign settled = (cnt_q == CntLast);
  // Abort wins over everything, including a handshake on the same edge.
  assign kill    = abort && (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:   if (start) state_d = StSettle;
        StSettle: if (settled) state_d = StOutput;
        StOutput: if (m_ready) state_d = (idx_q == IdxLast) ? StDone : StSettle;
        StDone:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    m_valid   = (state_q == StOutput);
    m_last    = (state_q == StOutput) && (idx_q == IdxLast);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    x_o       = x_q;
    m_data    = data_q;
    m_index   = idx_q;
    signature = sig_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    x_d    = x_q;
    idx_d  = idx_q;
    data_d = data_q;
    sig_d  = sig_q;
    if (!kill) begin
      case (state_q)
        StIdle: begin
          if (start) begin
            x_d   = '0;
            cnt_d = '0;
            sig_d = '0;
          end
        end
        StSettle: begin
          if (settled) begin
            data_d = f_i;
            idx_d  = x_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StOutput: begin
          if (m_ready) begin
            sig_d = {sig_q[OUT_WIDTH-2:0], sig_q[OUT_WIDTH-1]} ^ data_q;
            // x_o parks at the final index after the last beat, so it never wraps.
            if (idx_q != IdxLast) begin
              x_d   = x_q + 1'b1;
              cnt_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      x_q    <= '0;
      idx_q  <= '0;
      data_q <= '0;
      sig_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      sig_q  <= sig_d;
    end
  end

endmodule

// File: tb/tb_lut_tt_capture.sv
// Directed bench for lut_tt_capture: a 10-input instance with f = 3x and a 4-input instance with
// SETTLE_CYCLES=3 whose LUT response lags x_o by two clocks.
module tb_lut_tt_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start_a, abort_a, ready_a;
  logic [9:0]  x_a, idx_a;
  logic [10:0] f_a, data_a, sig_a;
  logic        valid_a, last_a, busy_a, done_a;

  assign f_a = 11'(32'(x_a) * 3);

  lut_tt_capture #(.N_INPUTS(10), .OUT_WIDTH(11), .SETTLE_CYCLES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .x_o(x_a), .f_i(f_a),
    .m_valid(valid_a), .m_ready(ready_a), .m_data(data_a), .m_index(idx_a), .m_last(last_a),
    .busy(busy_a), .done(done_a), .signature(sig_a)
  );

  logic       start_b, abort_b, ready_b;
  logic [3:0] x_b, idx_b, f_b, data_b, sig_b, d1_b, d2_b;
  logic       valid_b, last_b, busy_b, done_b;

  always_ff @(posedge clk) begin
    d1_b <= x_b;
    d2_b <= d1_b;
  end
  assign f_b = d2_b;

  lut_tt_capture #(.N_INPUTS(4), .OUT_WIDTH(4), .SETTLE_CYCLES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .x_o(x_b), .f_i(f_b),
    .m_valid(valid_b), .m_ready(ready_b), .m_data(data_b), .m_index(idx_b), .m_last(last_b),
    .busy(busy_b), .done(done_b), .signature(sig_b)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [10:0] ref_sig_a;
  logic [3:0]  ref_sig_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] sig_step(input logic [10:0] s, input logic [10:0] d);
    return {s[9:0], s[10]} ^ d;
  endfunction

  function automatic logic [10:0] lut_a(input int i);
    return 11'(i * 3);
  endfunction

  // Full sweep on instance A; rnd toggles m_ready randomly to exercise stalls.
  task automatic sweep_a(input bit rnd, input string tag);
    int          idx = 0;
    int          cyc = 0;
    bit          fin = 0;
    logic [10:0] s   = '0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check({tag, "_busy"}, 64'(busy_a), 64'd1);
    while (!fin && cyc < 8000) begin
      if (done_a) begin
        fin = 1;
      end else begin
        ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (valid_a) begin
          check({tag, "_beat"}, {x_a, idx_a, data_a, last_a},
                {10'(idx), 10'(idx), lut_a(idx), 1'(idx == 1023)});
          if (ready_a) begin
            s = sig_step(s, lut_a(idx));
            idx++;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    ready_a = 1'b1;
    check({tag, "_done_seen"}, 64'(fin), 64'd1);
    check({tag, "_beats"}, 64'(idx), 64'd1024);
    if (!rnd) check({tag, "_cycles"}, 64'(cyc), 64'd2048);
    check({tag, "_sig_run"}, 64'(sig_a), 64'(s));
    check({tag, "_sig_ref"}, 64'(sig_a), 64'(ref_sig_a));
    check({tag, "_x_final"}, 64'(x_a), 64'd1023);
    @(negedge clk);
    check({tag, "_idle"}, {busy_a, done_a, valid_a, last_a, x_a}, {4'b0000, 10'd1023});
  endtask

  // Starts a sweep on A and runs with m_ready high until the beat for target is presented.
  task automatic run_to_a(input int target, input string tag, output logic [10:0] s);
    int idx = 0;
    bit hit = 0;
    s       = '0;
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (valid_a && idx == target) begin
        hit = 1;
        break;
      end
      if (valid_a) begin
        s = sig_step(s, lut_a(idx));
        idx++;
      end
      @(negedge clk);
    end
    check({tag, "_reached"}, 64'(hit), 64'd1);
    check({tag, "_beat"}, {idx_a, data_a}, {10'(target), lut_a(target)});
  endtask

  task automatic sweep_b(input string tag);
    int idx = 0;
    int cyc = 0;
    bit fin = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    while (!fin && cyc < 1000) begin
      start_b = 1'b0;
      if (done_b) begin
        fin = 1;
      end else begin
        if (valid_b) begin
          check({tag, "_beat"}, {idx_b, data_b, last_b}, {4'(idx), 4'(idx), 1'(idx == 15)});
          // A start mid-sweep must be ignored.
          if (idx == 10) start_b = 1'b1;
          idx++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start_b = 1'b0;
    check({tag, "_done_seen"}, 64'(fin), 64'd1);
    check({tag, "_beats"}, 64'(idx), 64'd16);
    check({tag, "_cycles"}, 64'(cyc), 64'd64);
    check({tag, "_sig_ref"}, 64'(sig_b), 64'(ref_sig_b));
  endtask

  initial begin
    logic [10:0] s;
    rst_n   = 1'b0;
    start_a = 1'b0;
    abort_a = 1'b0;
    ready_a = 1'b1;
    start_b = 1'b0;
    abort_b = 1'b0;
    ready_b = 1'b1;

    ref_sig_a = '0;
    for (int i = 0; i < 1024; i++) ref_sig_a = sig_step(ref_sig_a, lut_a(i));
    ref_sig_b = '0;
    for (int i = 0; i < 16; i++) ref_sig_b = {ref_sig_b[2:0], ref_sig_b[3]} ^ 4'(i);

    repeat (2) @(negedge clk);
    check("reset_a", {x_a, valid_a, data_a, idx_a, last_a, busy_a, done_a, sig_a}, 64'd0);
    check("reset_b", {x_b, valid_b, data_b, idx_b, last_b, busy_b, done_b, sig_b}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    sweep_a(1'b0, "sweep_fast");
    sweep_a(1'b1, "sweep_rand");

    // Abort at index 37 with m_ready high: abort must beat the handshake.
    run_to_a(37, "abort_run", s);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("abort_state", {valid_a, busy_a, done_a, last_a}, 64'd0);
    check("abort_sig_held", 64'(sig_a), 64'(s));
    @(negedge clk);
    check("abort_no_done", {done_a, busy_a}, 64'd0);

    // Restart from 0, then reset at index 500.
    run_to_a(500, "restart_run", s);
    rst_n = 1'b0;
    #1;
    check("async_reset", {x_a, valid_a, data_a, idx_a, last_a, busy_a, done_a, sig_a}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_to_a(0, "post_reset", s);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("post_reset_idle", 64'(busy_a), 64'd0);

    sweep_b("settle3_first");
    repeat (3) @(negedge clk);
    sweep_b("settle3_second");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_tt_capture.md
LUT_TT_CAPTURE -- requirements
Module: lut_tt_capture

Interface
REQ-001 SHALL have parameter N_INPUTS, default 10, meaning the LUT input width swept exhaustively.
REQ-002 SHALL have parameter OUT_WIDTH, default 11, meaning the LUT output width captured per vector.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of clocks x_o is held before f_i is sampled; legal range is 1..255.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
REQ-007 abort  input  1  synchronous cancel of a sweep in progress.
REQ-008 x_o  output  N_INPUTS  vector driven to the LUT under test.
REQ-009 f_i  input  OUT_WIDTH  LUT response, treated as combinational from x_o.
REQ-010 m_valid / m_ready  output / input  1 / 1  capture stream handshake.
REQ-011 m_data  output  OUT_WIDTH  captured f_i for the current beat.
REQ-012 m_index  output  N_INPUTS  x value that produced m_data.
REQ-013 m_last  output  1  high on the beat for index 2^N_INPUTS-1.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when a sweep completes normally.
REQ-016 signature  output  OUT_WIDTH  running signature of all accepted beats.

Function
REQ-017 SHALL implement the states IDLE, SETTLE, OUTPUT, and DONE.
REQ-018 IDLE plus start SHALL go to SETTLE next cycle, with x_o=0, the settle counter=0, and signature=0.
REQ-019 SETTLE SHALL hold x_o stable for exactly SETTLE_CYCLES cycles, then register f_i into m_data and x_o into m_index, and go to OUTPUT.
REQ-020 OUTPUT SHALL assert m_valid and SHALL hold m_data, m_index, and m_last stable until m_valid&&m_ready.
REQ-021 On an accepted beat that is not the last, OUTPUT SHALL increment x_o by 1, clear the settle counter, and return to SETTLE.
REQ-022 On an accepted beat where m_last=1, OUTPUT SHALL go to DONE.
REQ-023 DONE SHALL assert done for one cycle and then return to IDLE; x_o SHALL hold its final value 2^N_INPUTS-1 until the next start.
REQ-024 On each accepted beat, signature SHALL update to {signature[OUT_WIDTH-2:0], signature[OUT_WIDTH-1]} XOR m_data.
REQ-025 When m_ready is held low, the FSM SHALL stall in OUTPUT indefinitely with no loss of data and no change to x_o.
REQ-026 With m_ready tied high, the throughput SHALL be one beat per SETTLE_CYCLES+1 cycles, and a full sweep SHALL take 2^N_INPUTS*(SETTLE_CYCLES+1) cycles from start to done.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 abort in any non-IDLE state SHALL go to IDLE next cycle with m_valid=0, done=0, no m_last issued, and signature held.
REQ-029 abort SHALL take priority over a simultaneous handshake.
REQ-030 x_o and m_index SHALL never wrap; an increment past 2^N_INPUTS-1 is unreachable by construction.
REQ-031 Counters SHALL be sized to ceil(log2(SETTLE_CYCLES+1)) bits.

Reset
REQ-032 rst_n low SHALL force, asynchronously, state=IDLE and x_o=0, m_valid=0, m_data=0, m_index=0, m_last=0, busy=0, done=0, signature=0.
REQ-033 Reset asserted mid-sweep SHALL discard all progress, and a subsequent start SHALL restart from index 0.

Verification
REQ-034 N_INPUTS=10, SETTLE_CYCLES=1, f_i = x_o*3 mod 2^11, m_ready=1, pulse start -> 1024 beats with m_data[i]=3i mod 2048, m_last only at i=1023, done 2048 cycles after start.
REQ-035 Same setup with m_ready toggled randomly -> identical beat sequence, identical final signature, and m_data stable during every stall.
REQ-036 Pulse abort at index 37 -> m_valid low next cycle, busy=0, no done, no m_last; a later start begins at index 0.
REQ-037 Drive rst_n low at index 500 -> all outputs zero immediately, without waiting for a clock edge.
REQ-038 SETTLE_CYCLES=3, f_i = x_o delayed 2 cycles -> every m_data equals its m_index (checks the sample point); pulse start at index 10 -> no effect on the sweep.
REQ-039 The final signature SHALL match a reference model of REQ-024 over the LUT's full truth table.
